nn_weightupdate_polar: RTL and testbench
========================================

NN_WEIGHTUPDATE_POLAR -- requirements
Module: nn_weightupdate_polar

Interface
REQ-001 SHALL have parameter N, default 25, the number of synapses (presynaptic neurons) in one weight column.
REQ-002 SHALL have parameter WB, default 8, the weight magnitude bits; a weight is signed with WB+1 bits.
REQ-003 SHALL have parameter CW, default 10, the signed gradient accumulator width.
REQ-004 SHALL have parameter EPOCH, default 256, the number of enabled cycles per weight commit.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port INIT, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port EN, input, 1 bit: learning enable; the block accumulates and counts only on EN cycles.
REQ-008 SHALL have port z, input, N bits: presynaptic activation streams.
REQ-009 SHALL have port delta, input, 1 bit: postsynaptic delta stream magnitude.
REQ-010 SHALL have port SIGN_delta, input, 1 bit: delta sign; 1 means negative.
REQ-011 SHALL have port R_eta, input, 1 bit: learning-rate gating random bit.
REQ-012 SHALL have port R_w, input, WB bits: random number for weight stream generation.
REQ-013 SHALL have ports LD_VALID (input, 1 bit), LD_ADDR (input, 5 bits) and LD_DATA (input, WB+1 bits, two's complement): weight load.
REQ-014 SHALL have ports alpha and SIGN_alpha, output, N bits each: weight magnitude and sign streams.
REQ-015 SHALL have port EPOCH_DONE, output, 1 bit: one-cycle commit pulse.

Function
REQ-016 SHALL compute, per synapse i, g_i = z[i] & delta & R_eta & EN.
REQ-017 SHALL update ACC_i on a non-commit cycle when g_i=1: ACC_i +1 if SIGN_delta=0, -1 if SIGN_delta=1; ACC_i SHALL saturate at ±(2^(CW-1)-1).
REQ-018 SHALL increment epoch counter E (0..EPOCH-1) on each EN cycle and hold it on EN=0 cycles.
REQ-019 SHALL commit on an EN cycle with E=EPOCH-1: W_i <= sat(W_i - (ACC_i + that cycle's contribution)); ACC_i <= 0; E <= 0.
REQ-020 SHALL saturate W_i symmetrically to [-(2^WB-1), +(2^WB-1)].
REQ-021 SHALL drive EPOCH_DONE=1 for exactly the one cycle after a commit.
REQ-022 SHALL write LD_DATA, saturated, into W[LD_ADDR] when LD_VALID=1, and SHALL ignore LD_ADDR>=N.
REQ-023 SHALL let a load win over the commit for the addressed synapse when both occur in the same cycle; that synapse's ACC SHALL still clear.
REQ-024 SHALL register the outputs with 1-cycle latency: alpha[i](t+1) = (|W_i(t)| > R_w(t)), strictly greater; SIGN_alpha[i](t+1) = (W_i(t) < 0).
REQ-025 SHALL make W=0 produce alpha=0 and SIGN_alpha=0.

Reset
REQ-026 SHALL, on INIT=1 at a clock edge, clear all W_i, ACC_i and E, and drive alpha=0, SIGN_alpha=0 and EPOCH_DONE=0, overriding EN and LD_VALID.
REQ-027 SHALL discard a partial epoch when INIT is asserted mid-epoch; the next commit SHALL occur after a full EPOCH enabled cycles.

Structure
REQ-028 SHALL place WB, CW, the weight and accumulator typedefs, and the saturating add/sub function in shared package nn_snn_pkg.
REQ-029 SHALL implement each synapse (ACC, W, comparator, output registers) in sub-module nn_synapse_update, instantiated N times by generate; E, EPOCH_DONE and the load decode SHALL be top-level.

Verification
REQ-030 SHALL verify: INIT pulse, then EN=0 with random inputs for 50 cycles -> alpha=0, SIGN_alpha=0, EPOCH_DONE=0.
REQ-031 SHALL verify: load W[3]=+100, R_w=50 -> alpha[3]=1, SIGN_alpha[3]=0 one cycle later; R_w=100 -> alpha[3]=0.
REQ-032 SHALL verify: z[0]=1, delta=1, SIGN_delta=0, R_eta=1, EN=1 for 256 cycles from W=0 -> EPOCH_DONE pulses after cycle 256; W[0]=-255 (saturated); SIGN_alpha[0]=1; alpha[0]=1 for R_w<255.
REQ-033 SHALL verify: LD_VALID with LD_ADDR=5 and LD_DATA=-20 on the commit cycle, with ACC_5=+7 -> W[5]=-20, ACC_5=0.
REQ-034 SHALL verify: INIT at enabled cycle 100 -> W cleared; next EPOCH_DONE exactly 256 EN cycles after INIT deasserts.
REQ-035 SHALL verify: EN toggled 50% with the scenario-3 stimulus -> EPOCH_DONE after 512 cycles, W[0]=-255.

Source files
------------

// File: rtl/nn_snn_pkg.sv
// Shared widths, weight/accumulator types and the clamping helper used by
// the polar weight-update column and its per-synapse slices.
package nn_snn_pkg;

  localparam int WB = 8;
  localparam int CW = 10;

  typedef logic signed [WB:0]   weight_t;
  typedef logic signed [CW-1:0] acc_t;

  // a + b clamped symmetrically to [-lim, +lim]
  function automatic int sat_add(input int a, input int b, input int lim);
    int s;
    s = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/nn_synapse_update.sv
// One synapse of the column: signed gradient accumulator, signed weight,
// and the registered stochastic magnitude/sign stream generator.
module nn_synapse_update #(
  parameter int WB = nn_snn_pkg::WB,
  parameter int CW = nn_snn_pkg::CW
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic                 g,
  input  logic                 sign_d,
  input  logic                 commit,
  input  logic                 ld,
  input  logic signed [WB:0]   ld_data,
  input  logic        [WB-1:0] r_w,
  output logic                 alpha,
  output logic                 sign_alpha
);
  import nn_snn_pkg::*;

  localparam int W_MAX   = (1 << WB) - 1;
  localparam int ACC_MAX = (1 << (CW - 1)) - 1;

  logic signed [WB:0]   w;
  logic signed [CW-1:0] acc;
  int acc_sum;
  int w_commit;
  int w_mag;

  // Accumulator including this cycle's contribution, the committed weight, and |W|
  always_comb begin
    acc_sum  = sat_add(int'(acc), g ? (sign_d ? -1 : 1) : 0, ACC_MAX);
    w_commit = sat_add(int'(w), -acc_sum, W_MAX);
    w_mag    = (w < 0) ? -int'(w) : int'(w);
  end

  // Weight/accumulator state; a load takes priority over the commit, ACC still clears
  always_ff @(posedge clk) begin
    if (init) begin
      w          <= '0;
      acc        <= '0;
      alpha      <= 1'b0;
      sign_alpha <= 1'b0;
    end else begin
      if (ld)
        w <= (WB+1)'(sat_add(int'(ld_data), 0, W_MAX));
      else if (commit)
        w <= (WB+1)'(w_commit);
      if (commit)
        acc <= '0;
      else if (g)
        acc <= CW'(acc_sum);
      alpha      <= w_mag > int'({1'b0, r_w});
      sign_alpha <= w[WB];
    end
  end

endmodule

// File: rtl/nn_weightupdate_polar.sv
// Polar stochastic weight-update column: epoch counter, commit pulse and
// weight-load decode, with one nn_synapse_update slice per presynaptic input.
module nn_weightupdate_polar #(
  parameter int N     = 25,
  parameter int WB    = nn_snn_pkg::WB,
  parameter int CW    = nn_snn_pkg::CW,
  parameter int EPOCH = 256
) (
  input  logic                 CLK,
  input  logic                 INIT,
  input  logic                 EN,
  input  logic [N-1:0]         z,
  input  logic                 delta,
  input  logic                 SIGN_delta,
  input  logic                 R_eta,
  input  logic [WB-1:0]        R_w,
  input  logic                 LD_VALID,
  input  logic [4:0]           LD_ADDR,
  input  logic signed [WB:0]   LD_DATA,
  output logic [N-1:0]         alpha,
  output logic [N-1:0]         SIGN_alpha,
  output logic                 EPOCH_DONE
);

  localparam int EW = (EPOCH > 1) ? $clog2(EPOCH) : 1;

  logic [EW-1:0] e;
  logic          commit;
  logic [N-1:0]  g;
  logic [N-1:0]  ld;

  assign commit = EN && (e == EW'(EPOCH - 1));

  // Per-synapse gradient gates and load-address decode (addresses >= N hit nothing)
  always_comb begin
    g  = z & {N{delta & R_eta & EN}};
    ld = '0;
    for (int i = 0; i < N; i++)
      ld[i] = LD_VALID && (LD_ADDR == 5'(i));
  end

  // Epoch counter advances only on enabled cycles; commit pulse lags by one cycle
  always_ff @(posedge CLK) begin
    if (INIT) begin
      e          <= '0;
      EPOCH_DONE <= 1'b0;
    end else begin
      EPOCH_DONE <= commit;
      if (EN)
        e <= commit ? '0 : e + 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : gen_syn
    nn_synapse_update #(.WB(WB), .CW(CW)) u_syn (
      .clk        (CLK),
      .init       (INIT),
      .g          (g[i]),
      .sign_d     (SIGN_delta),
      .commit     (commit),
      .ld         (ld[i]),
      .ld_data    (LD_DATA),
      .r_w        (R_w),
      .alpha      (alpha[i]),
      .sign_alpha (SIGN_alpha[i])
    );
  end

endmodule

// File: tb/tb_nn_weightupdate_polar.sv
// Directed + randomized bench for nn_weightupdate_polar against a
// behavioural model of the column's update rules.
module tb_nn_weightupdate_polar;

  localparam int N     = 25;
  localparam int WB    = 8;
  localparam int CW    = 10;
  localparam int EPOCH = 256;
  localparam int WMAX  = 255;
  localparam int AMAX  = 511;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                 INIT, EN, delta, SIGN_delta, R_eta, LD_VALID;
  logic [N-1:0]         z;
  logic [WB-1:0]        R_w;
  logic [4:0]           LD_ADDR;
  logic signed [WB:0]   LD_DATA;
  logic [N-1:0]         alpha, SIGN_alpha;
  logic                 EPOCH_DONE;

  nn_weightupdate_polar #(.N(N), .WB(WB), .CW(CW), .EPOCH(EPOCH)) dut (
    .CLK(CLK), .INIT(INIT), .EN(EN), .z(z), .delta(delta),
    .SIGN_delta(SIGN_delta), .R_eta(R_eta), .R_w(R_w),
    .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .alpha(alpha), .SIGN_alpha(SIGN_alpha), .EPOCH_DONE(EPOCH_DONE)
  );

  int mw[N];
  int macc[N];
  int me;
  int n_pass  = 0;
  int n_total = 0;
  logic [N-1:0] exp_alpha, exp_sign;
  logic         exp_done;

  function automatic int clamp(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // Advance the model by one clock, then clock the DUT and compare all outputs.
  task automatic step();
    bit commit, gi;
    int mag, c, s;
    if (INIT) begin
      exp_alpha = '0; exp_sign = '0; exp_done = 1'b0;
      for (int i = 0; i < N; i++) begin mw[i] = 0; macc[i] = 0; end
      me = 0;
    end else begin
      commit   = EN && (me == EPOCH - 1);
      exp_done = commit;
      for (int i = 0; i < N; i++) begin
        mag          = (mw[i] < 0) ? -mw[i] : mw[i];
        exp_alpha[i] = mag > int'(R_w);
        exp_sign[i]  = mw[i] < 0;
        gi = z[i] && delta && R_eta && EN;
        c  = gi ? (SIGN_delta ? -1 : 1) : 0;
        s  = clamp(macc[i] + c, AMAX);
        if (commit) begin
          mw[i]   = clamp(mw[i] - s, WMAX);
          macc[i] = 0;
        end else begin
          macc[i] = s;
        end
        if (LD_VALID && int'(LD_ADDR) == i) mw[i] = clamp(int'(LD_DATA), WMAX);
      end
      if (EN) me = commit ? 0 : me + 1;
    end
    @(posedge CLK);
    #1;
    chk("alpha", 32'(alpha), 32'(exp_alpha));
    chk("sign_alpha", 32'(SIGN_alpha), 32'(exp_sign));
    chk("epoch_done", 32'(EPOCH_DONE), 32'(exp_done));
  endtask

  task automatic idle();
    INIT = 0; EN = 0; z = '0; delta = 0; SIGN_delta = 0; R_eta = 0;
    R_w = '0; LD_VALID = 0; LD_ADDR = '0; LD_DATA = '0;
  endtask

  task automatic rand_in();
    z = N'($urandom); delta = 1'($urandom); SIGN_delta = 1'($urandom);
    R_eta = 1'($urandom); R_w = WB'($urandom);
  endtask

  task automatic do_init();
    idle(); INIT = 1; step(); INIT = 0;
  endtask

  task automatic scen3(input bit en);
    idle(); z = N'(1); delta = 1; R_eta = 1; EN = en; R_w = WB'($urandom);
  endtask

  // |W[idx]| == mag checked via the strict comparator at thresholds mag-1 and mag
  task automatic probe_w(input int idx, input int mag, input bit neg);
    idle(); R_w = WB'(mag - 1); step();
    chk("probe_alpha_hi", 32'(alpha[idx]), 32'(1));
    chk("probe_sign", 32'(SIGN_alpha[idx]), 32'(neg));
    R_w = WB'(mag); step();
    chk("probe_alpha_lo", 32'(alpha[idx]), 32'(0));
  endtask

  initial begin
    idle();
    for (int i = 0; i < N; i++) begin mw[i] = 0; macc[i] = 0; end
    me = 0;

    // Reset, then 50 disabled cycles with random inputs
    do_init(); do_init();
    for (int n = 0; n < 50; n++) begin
      idle(); rand_in(); step();
      chk("s1_alpha0", 32'(alpha), 32'(0));
      chk("s1_sign0", 32'(SIGN_alpha), 32'(0));
      chk("s1_done0", 32'(EPOCH_DONE), 32'(0));
    end

    // Load W[3]=+100 and compare against R_w; load saturation of -256
    idle(); LD_VALID = 1; LD_ADDR = 5'd3; LD_DATA = 9'sd100; step();
    idle(); R_w = 8'd50; step();
    chk("s2_alpha3_50", 32'(alpha[3]), 32'(1));
    chk("s2_sign3", 32'(SIGN_alpha[3]), 32'(0));
    idle(); R_w = 8'd100; step();
    chk("s2_alpha3_100", 32'(alpha[3]), 32'(0));
    idle(); LD_VALID = 1; LD_ADDR = 5'd7; LD_DATA = -9'sd256; step();
    probe_w(7, 255, 1'b1);

    // Full epoch of positive gradient on synapse 0
    do_init();
    for (int n = 1; n <= 256; n++) begin
      scen3(1'b1); step();
      chk("s3_done", 32'(EPOCH_DONE), 32'(n == 256));
    end
    probe_w(0, 255, 1'b1);

    // Load on the commit cycle wins; ACC_5=+7 is discarded
    do_init();
    for (int n = 1; n <= 256; n++) begin
      idle(); rand_in(); EN = 1;
      z[5] = (n <= 7);
      if (n <= 7) begin delta = 1; R_eta = 1; SIGN_delta = 0; end
      if (n == 100) begin LD_VALID = 1; LD_ADDR = 5'd30; LD_DATA = 9'($urandom); end
      if (n == 256) begin LD_VALID = 1; LD_ADDR = 5'd5; LD_DATA = -9'sd20; end
      step();
      chk("s4_done", 32'(EPOCH_DONE), 32'(n == 256));
    end
    probe_w(5, 20, 1'b1);
    for (int n = 1; n <= 256; n++) begin
      idle(); EN = 1; R_w = WB'($urandom); step();
    end
    probe_w(5, 20, 1'b1);

    // INIT mid-epoch discards the partial epoch
    do_init();
    for (int n = 0; n < 100; n++) begin scen3(1'b1); step(); end
    scen3(1'b1); INIT = 1; step(); INIT = 0;
    for (int n = 1; n <= 256; n++) begin
      scen3(1'b1);
      if (n == 1) R_w = '0;
      step();
      if (n == 1) begin
        chk("s5_cleared_alpha0", 32'(alpha[0]), 32'(0));
        chk("s5_cleared_sign0", 32'(SIGN_alpha[0]), 32'(0));
      end
      chk("s5_done", 32'(EPOCH_DONE), 32'(n == 256));
    end

    // EN at 50% duty: commit after 512 cycles
    do_init();
    for (int n = 1; n <= 512; n++) begin
      scen3(n % 2 == 0); step();
      chk("s6_done", 32'(EPOCH_DONE), 32'(n == 512));
    end
    probe_w(0, 255, 1'b1);

    // Random soak: everything random, occasional loads and resets
    for (int n = 0; n < 700; n++) begin
      idle(); rand_in();
      EN       = ($urandom_range(3, 0) != 0);
      LD_VALID = ($urandom_range(7, 0) == 0);
      LD_ADDR  = 5'($urandom);
      LD_DATA  = 9'($urandom);
      INIT     = ($urandom_range(255, 0) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
